// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (radix-2 shift-add, restoring divide), 34-cycle latency.
// Optional macro MULDIV_FAST_SPECIAL_EN: special operands skip CALC and finish in 2 cycles.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);
  localparam int AW = 2*XLEN+1;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  function automatic logic op1_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b010, 3'b100, 3'b110: op1_signed = 1'b1;
      default:                        op1_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op2_signed(input logic [2:0] f);
    case (f)
      3'b001, 3'b100, 3'b110: op2_signed = 1'b1;
      default:                op2_signed = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] abs_if(input logic neg, input logic [XLEN-1:0] v);
    if (neg) abs_if = ZERO - v;
    else     abs_if = v;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d, mag_q, mag_d, result_q, result_d;
  logic              sign1_q, sign1_d, sign2_q, sign2_d, done_q, done_d, busy_q, busy_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              is_div_s, div_zero_s, div_ovf_s, mul_zero_s, skip_calc_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN+1:0]   div_diff_s;
  logic [AW-1:0]     mul_step_s, div_shl_s, div_step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_result_s;

  // Iteration arithmetic, special-case detection and final result selection
  always_comb begin
    is_div_s   = funct3_q[2];
    div_zero_s = is_div_s && (op2_q == ZERO);
    div_ovf_s  = ((funct3_q == 3'b100) || (funct3_q == 3'b110)) &&
                 (op1_q == INT_MIN) && (op2_q == ALL_ONES);
    mul_zero_s = !is_div_s && ((op1_q == ZERO) || (op2_q == ZERO));

    // Accumulator layout: multiply {product_hi(XLEN+1), multiplier}, divide {remainder(XLEN+1), quotient}
    mul_sum_s  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
    mul_step_s = {1'b0, mul_sum_s, acc_q[XLEN-1:1]};
    div_shl_s  = {acc_q[AW-2:0], 1'b0};
    div_diff_s = {1'b0, div_shl_s[AW-1:XLEN]} - {2'b00, mag_q};
    if (!div_diff_s[XLEN+1]) div_step_s = {div_diff_s[XLEN:0], div_shl_s[XLEN-1:1], 1'b1};
    else                     div_step_s = div_shl_s;

    if (sign1_q ^ sign2_q) prod_s = {(2*XLEN){1'b0}} - acc_q[2*XLEN-1:0];
    else                   prod_s = acc_q[2*XLEN-1:0];
    if (sign1_q ^ sign2_q) quo_s = ZERO - acc_q[XLEN-1:0];
    else                   quo_s = acc_q[XLEN-1:0];
    if (sign1_q)           rem_s = ZERO - acc_q[2*XLEN-1:XLEN];
    else                   rem_s = acc_q[2*XLEN-1:XLEN];

    case (funct3_q)
      3'b000: begin
        if (mul_zero_s) fin_result_s = ZERO;
        else            fin_result_s = prod_s[XLEN-1:0];
      end
      3'b001, 3'b010, 3'b011: begin
        if (mul_zero_s) fin_result_s = ZERO;
        else            fin_result_s = prod_s[2*XLEN-1:XLEN];
      end
      3'b100, 3'b101: begin
        if (div_zero_s)     fin_result_s = ALL_ONES;
        else if (div_ovf_s) fin_result_s = INT_MIN;
        else                fin_result_s = quo_s;
      end
      3'b110, 3'b111: begin
        if (div_zero_s)     fin_result_s = op1_q;
        else if (div_ovf_s) fin_result_s = ZERO;
        else                fin_result_s = rem_s;
      end
      default: fin_result_s = ZERO;
    endcase
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  assign skip_calc_s = div_zero_s | div_ovf_s | mul_zero_s;
`else
  assign skip_calc_s = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) state_d = S_PREP;
        else                 state_d = S_IDLE;
      end
      S_PREP: begin
        if (FLUSH)            state_d = S_IDLE;
        else if (skip_calc_s) state_d = S_FIN;
        else                  state_d = S_CALC;
      end
      S_CALC: begin
        if (FLUSH)                  state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_FIN;
        else                        state_d = S_CALC;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    funct3_d = funct3_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    mag_d    = mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) begin
          funct3_d = FUNCT3;
          op1_d    = OPERAND1;
          op2_d    = OPERAND2;
        end else begin
          funct3_d = funct3_q;
        end
      end
      S_PREP: begin
        sign1_d = op1_signed(funct3_q) & op1_q[XLEN-1];
        sign2_d = op2_signed(funct3_q) & op2_q[XLEN-1];
        cnt_d   = {CW{1'b0}};
        if (is_div_s) begin
          acc_d = {{(XLEN+1){1'b0}}, abs_if(sign1_d, op1_q)};
          mag_d = abs_if(sign2_d, op2_q);
        end else begin
          acc_d = {{(XLEN+1){1'b0}}, abs_if(sign2_d, op2_q)};
          mag_d = abs_if(sign1_d, op1_q);
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1'b1);
        if (is_div_s) acc_d = div_step_s;
        else          acc_d = mul_step_s;
      end
      S_FIN: begin
        if (!FLUSH) begin
          result_d = fin_result_s;
          done_d   = 1'b1;
        end else begin
          done_d   = 1'b0;
        end
      end
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      funct3_q <= 3'b000;
      op1_q    <= ZERO;
      op2_q    <= ZERO;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mag_q    <= ZERO;
      acc_q    <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= ZERO;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      funct3_q <= funct3_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      mag_q    <= mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the EX stage.
- Consumes the M-extension operations decoded by the control unit; the ID/EX register supplies the operands and funct3.
- Runs 32-cycle radix-2 shift-add multiply and restoring divide.
- Drives BUSY so the hazard logic stalls the pipeline, then returns RESULT with a one-cycle DONE pulse.

Parameters:
- XLEN, 32, operand/result width (only 32 is supported; the iteration counter is sized from it).

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- FUNCT3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND1  input  XLEN  rs1 value (multiplicand/dividend).
- OPERAND2  input  XLEN  rs2 value (multiplier/divisor).
- FLUSH  input  1  abort current operation (branch/jump squash).
- BUSY  output  1  high whenever state != IDLE.
- DONE  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  XLEN  result; held until the next accepted START.

Behaviour:
- Reset: CLK runs continuously; RESET is asynchronous and active-low. While RESET=0: state IDLE, BUSY=0, DONE=0, RESULT=0, all internal registers 0. Assertion mid-operation aborts immediately and produces no DONE.
- States: IDLE, PREP, CALC, FIN.
- IDLE:
  - START=1 and FLUSH=0 at an edge: latch FUNCT3 and operands, go to PREP.
  - Otherwise stay in IDLE.
- PREP (1 cycle):
  - Record operand signs per op: MULH/DIV/REM both signed; MULHSU OPERAND1 signed only; MULHU/DIVU/REMU/MUL unsigned magnitudes.
  - Take absolute values, clear the 2*XLEN accumulator and the counter, go to CALC.
- CALC (exactly XLEN cycles): one iteration per edge.
  - Multiply: if multiplier LSB is set, add the multiplicand into the accumulator upper half; shift right.
  - Divide: shift remainder:quotient left; trial-subtract the divisor; keep the result if non-negative and set quotient bit 0.
  - Counter reaching XLEN-1 moves to FIN.
- FIN (1 cycle):
  - Negate the product if signs differ.
  - Quotient is negated if dividend and divisor signs differ; remainder takes the dividend's sign.
  - Select low word (MUL), high word (MULH*), quotient or remainder.
  - On the exiting edge, register RESULT, set DONE=1 for one cycle, return to IDLE.
- Latency: START sampled at edge 0 gives DONE high in the cycle following edge 34; BUSY is high for cycles 1..34.
- Special cases (RISC-V mandated, no trap):
  - Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU return OPERAND1.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM 0.
  - These are forced in FIN regardless of the datapath contents.
- START while BUSY: ignored, latched operands are unchanged.
- START in the DONE cycle (state IDLE): accepted, so back-to-back operations are legal.
- FLUSH:
  - In PREP/CALC/FIN: next edge returns to IDLE, no DONE, RESULT unchanged.
  - In IDLE with START: FLUSH wins and START is dropped.
- Width: all intermediate arithmetic is 2*XLEN+1 bits so MULHSU/MULHU never overflow.

Optional Feature:
- Macro MULDIV_FAST_SPECIAL_EN.
- Defined: PREP detects divide-by-zero, signed overflow, or either multiply operand zero, and goes straight to FIN, skipping CALC. DONE is high in the cycle after edge 2; all other operations keep the 34-cycle latency.
- Undefined: every operation takes exactly 34 cycles and the special-case results are applied only in FIN.

Test Plan:
- MUL 7 x 0xFFFFFFFD: RESULT 0xFFFFFFEB, DONE exactly at cycle 34, BUSY high cycles 1..34.
- MULH 0x80000000 x 0x80000000 gives 0x40000000; MULHU of the same gives 0x40000000; MULHSU 0xFFFFFFFF x 2 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- DIVU 17 / 0 gives 0xFFFFFFFF; REMU 17 / 0 gives 17. With MULDIV_FAST_SPECIAL_EN, DONE arrives at cycle 2.
- START with DIV 100/7, FLUSH at cycle 10: BUSY=0 at cycle 11, no DONE, RESULT unchanged. A second START issued during BUSY is ignored.
- RESET pulled low at cycle 20 of a MUL: BUSY/DONE/RESULT go to 0 immediately (asynchronously). A new START after release completes normally. Back-to-back START in the DONE cycle produces two DONE pulses 35 cycles apart.
